// File: rtl/mem_resp_pkg.sv
// ============================================================================
//  Module      : mem_resp_pkg
//  Description : Shared state encoding, UART register map and status bit
//                positions for the MEM-stage memory access responder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_resp_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SRAM_RD = 3'd1,
        SRAM_WR = 3'd2,
        WR_HOLD = 3'd3,
        UART_RD = 3'd4,
        UART_WR = 3'd5,
        DONE    = 3'd6
    } state_e;

    localparam logic [15:0] UART_DATA_ADDR_DEF = 16'hBF00;
    localparam logic [15:0] UART_STAT_ADDR_DEF = 16'hBF01;

    localparam int STAT_TX_RDY = 0;
    localparam int STAT_RX_RDY = 1;

    localparam int WCNT_W = 3;

endpackage : mem_resp_pkg

`default_nettype wire

// File: rtl/mem_access_responder_sync_2ff.sv
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer bank for asynchronous level inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule : sync_2ff

`default_nettype wire

// File: rtl/mem_access_responder.sv
// ============================================================================
//  Module      : mem_access_responder
//  Description : Serializes MEM-stage loads/stores onto external SRAM or the
//                memory-mapped UART, stalling the pipeline until done.
//                UART decode is built only when MEM_RESP_UART_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_responder
    import mem_resp_pkg::*;
#(
    parameter int          WAIT_CYCLES    = 1,
    parameter int          EXT_AW         = 18,
    parameter logic [15:0] UART_DATA_ADDR = UART_DATA_ADDR_DEF,
    parameter logic [15:0] UART_STAT_ADDR = UART_STAT_ADDR_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [15:0]       addr,
    input  logic [15:0]       wdata,
    output logic [15:0]       rdata,
    output logic              stall,
    output logic [EXT_AW-1:0] ram_addr,
    output logic [15:0]       ram_dq_o,
    input  logic [15:0]       ram_dq_i,
    output logic              ram_dq_oe,
    output logic              ram_en_n,
    output logic              ram_oe_n,
    output logic              ram_we_n,
    output logic              uart_rdn,
    output logic              uart_wrn,
    input  logic              uart_data_ready,
    input  logic              uart_tbre,
    input  logic              uart_tsre
);

    localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(WAIT_CYCLES - 1);

    state_e              state_q, state_d;
    logic [WCNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]         addr_q, addr_d;
    logic [15:0]         dq_o_q, dq_o_d;
    logic [15:0]         rdata_q, rdata_d;
    logic                uart_acc_q, uart_acc_d;
    logic                en_n_q, en_n_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;
    logic                rdn_q, rdn_d;
    logic                wrn_q, wrn_d;
    logic                dq_oe_q, dq_oe_d;

    logic                req;
    logic                data_hit;
    logic                stat_hit;
    logic [15:0]         status;

`ifdef MEM_RESP_UART_EN
    logic [2:0] uart_sync;

    sync_2ff #(
        .WIDTH (3)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i ({uart_data_ready, uart_tbre, uart_tsre}),
        .sync_o  (uart_sync)
    );

    always_comb begin
        status              = '0;
        status[STAT_RX_RDY] = uart_sync[2];
        status[STAT_TX_RDY] = uart_sync[1] & uart_sync[0];
    end

    assign data_hit = (addr == UART_DATA_ADDR);
    assign stat_hit = (addr == UART_STAT_ADDR);
    assign uart_rdn = rdn_q;
    assign uart_wrn = wrn_q;
`else
    // UART window is plain SRAM in this build; the UART pins stay idle.
    assign status   = '0;
    assign data_hit = 1'b0;
    assign stat_hit = 1'b0;
    assign uart_rdn = 1'b1;
    assign uart_wrn = 1'b1;

    logic unused_uart;
    assign unused_uart = &{1'b0, uart_data_ready, uart_tbre, uart_tsre,
                           rdn_q, wrn_q, UART_DATA_ADDR, UART_STAT_ADDR};
`endif

    assign req   = mem_read | mem_write;
    assign stall = ((state_q == IDLE) & req) |
                   ((state_q != IDLE) & (state_q != DONE));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        dq_o_d     = dq_o_q;
        rdata_d    = rdata_q;
        uart_acc_d = uart_acc_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d     = addr;
                    dq_o_d     = wdata;
                    cnt_d      = WAIT_INIT;
                    uart_acc_d = 1'b0;
                    if (mem_write) begin
                        if (data_hit) begin
                            state_d    = UART_WR;
                            dq_o_d     = {8'h00, wdata[7:0]};
                            uart_acc_d = 1'b1;
                        end else if (stat_hit) begin
                            state_d = DONE;
                        end else begin
                            state_d = SRAM_WR;
                        end
                    end else begin
                        if (data_hit) begin
                            state_d    = UART_RD;
                            uart_acc_d = 1'b1;
                        end else if (stat_hit) begin
                            state_d = DONE;
                            rdata_d = status;
                        end else begin
                            state_d = SRAM_RD;
                        end
                    end
                end
            end
            SRAM_RD: begin
                if (cnt_q == '0) begin
                    rdata_d = ram_dq_i;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            UART_RD: begin
                if (cnt_q == '0) begin
                    rdata_d = {8'h00, ram_dq_i[7:0]};
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SRAM_WR, UART_WR: begin
                if (cnt_q == '0) begin
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WR_HOLD: state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pin controls are decoded from the next state and registered so the
    // board sees glitch-free strobes aligned with the state they belong to.
    always_comb begin
        en_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        rdn_d   = 1'b1;
        wrn_d   = 1'b1;
        dq_oe_d = 1'b0;
        case (state_d)
            SRAM_RD: begin
                en_n_d = 1'b0;
                oe_n_d = 1'b0;
            end
            SRAM_WR: begin
                en_n_d  = 1'b0;
                we_n_d  = 1'b0;
                dq_oe_d = 1'b1;
            end
            WR_HOLD: begin
                en_n_d  = uart_acc_d;
                dq_oe_d = 1'b1;
            end
            UART_RD: rdn_d = 1'b0;
            UART_WR: begin
                wrn_d   = 1'b0;
                dq_oe_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            dq_o_q     <= '0;
            rdata_q    <= '0;
            uart_acc_q <= 1'b0;
            en_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            rdn_q      <= 1'b1;
            wrn_q      <= 1'b1;
            dq_oe_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            dq_o_q     <= dq_o_d;
            rdata_q    <= rdata_d;
            uart_acc_q <= uart_acc_d;
            en_n_q     <= en_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            rdn_q      <= rdn_d;
            wrn_q      <= wrn_d;
            dq_oe_q    <= dq_oe_d;
        end
    end

    assign rdata     = rdata_q;
    assign ram_addr  = {{(EXT_AW-16){1'b0}}, addr_q};
    assign ram_dq_o  = dq_o_q;
    assign ram_dq_oe = dq_oe_q;
    assign ram_en_n  = en_n_q;
    assign ram_oe_n  = oe_n_q;
    assign ram_we_n  = we_n_q;

endmodule : mem_access_responder

`default_nettype wire

// File: tb/tb_mem_access_responder.sv
// ============================================================================
//  Module      : tb_mem_access_responder
//  Description : Directed self-checking bench for mem_access_responder with a
//                behavioural SRAM/UART bus model (WAIT_CYCLES 1 and 3 units).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [15:0] addr, wdata, rdata, ram_dq_o, ram_dq_i;
    logic [17:0] ram_addr;
    logic        stall, ram_dq_oe, ram_en_n, ram_oe_n, ram_we_n;
    logic        uart_rdn, uart_wrn, uart_data_ready, uart_tbre, uart_tsre;

    logic        t3_rst, t3_rd, t3_wr;
    logic [15:0] t3_addr, t3_wdata, t3_rdata, t3_dq_o;
    logic [17:0] t3_ram_addr;
    logic        t3_stall, t3_dq_oe, t3_en_n, t3_oe_n, t3_we_n, t3_rdn, t3_wrn;

    logic [15:0] sram [0:65535];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_access_responder #(.WAIT_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
        .ram_addr(ram_addr), .ram_dq_o(ram_dq_o), .ram_dq_i(ram_dq_i),
        .ram_dq_oe(ram_dq_oe), .ram_en_n(ram_en_n), .ram_oe_n(ram_oe_n),
        .ram_we_n(ram_we_n), .uart_rdn(uart_rdn), .uart_wrn(uart_wrn),
        .uart_data_ready(uart_data_ready), .uart_tbre(uart_tbre),
        .uart_tsre(uart_tsre)
    );

    mem_access_responder #(.WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(t3_rst), .mem_read(t3_rd), .mem_write(t3_wr),
        .addr(t3_addr), .wdata(t3_wdata), .rdata(t3_rdata), .stall(t3_stall),
        .ram_addr(t3_ram_addr), .ram_dq_o(t3_dq_o), .ram_dq_i(16'h0000),
        .ram_dq_oe(t3_dq_oe), .ram_en_n(t3_en_n), .ram_oe_n(t3_oe_n),
        .ram_we_n(t3_we_n), .uart_rdn(t3_rdn), .uart_wrn(t3_wrn),
        .uart_data_ready(1'b0), .uart_tbre(1'b1), .uart_tsre(1'b1)
    );

    // External bus model: UART drives 0x5A77 while read-strobed, SRAM is async.
    always_comb begin
        if (!uart_rdn)                  ram_dq_i = 16'h5A77;
        else if (!ram_en_n && !ram_oe_n) ram_dq_i = sram[ram_addr[15:0]];
        else                            ram_dq_i = 16'hFFFF;
    end

    always @(posedge clk) begin
        if (!ram_en_n && !ram_we_n) sram[ram_addr[15:0]] <= ram_dq_o;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    int          n_stall, n_we, n_oe, n_rdoe, n_wrn, n_rdn, n_en;
    logic [15:0] dq_seen, rd_val;
    logic [17:0] addr_seen;

    // Presents one request at a negedge and watches it until stall drops
    // (the DONE cycle); the request is left asserted through DONE.
    task automatic do_acc(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] d);
        bit done = 0;
        @(negedge clk);
        mem_read = rd; mem_write = wr; addr = a; wdata = d;
        n_stall = 0; n_we = 0; n_oe = 0; n_rdoe = 0; n_wrn = 0; n_rdn = 0; n_en = 0;
        dq_seen = 16'hxxxx; rd_val = 16'hxxxx; addr_seen = '0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!stall) begin
                rd_val = rdata;
                done   = 1;
                break;
            end
            n_stall++;
            if (!ram_we_n) n_we++;
            if (!ram_oe_n) n_rdoe++;
            if (!uart_wrn) n_wrn++;
            if (!uart_rdn) n_rdn++;
            if (!ram_en_n) begin n_en++; addr_seen = ram_addr; end
            if (ram_dq_oe) begin n_oe++; dq_seen = ram_dq_o; end
            @(negedge clk);
        end
        chk("acc_timeout", {31'b0, done}, 32'd1);
    endtask

    task automatic idle_bus();
        @(negedge clk);
        mem_read = 0; mem_write = 0;
    endtask

    initial begin
        rst = 1; t3_rst = 1;
        mem_read = 0; mem_write = 0; addr = 0; wdata = 0;
        t3_rd = 0; t3_wr = 0; t3_addr = 0; t3_wdata = 0;
        uart_data_ready = 0; uart_tbre = 0; uart_tsre = 0;
        repeat (3) @(negedge clk);
        rst = 0; t3_rst = 0;
        #1;
        chk("reset_outs", {stall, ram_dq_oe, ram_en_n, ram_oe_n, ram_we_n, uart_rdn, uart_wrn},
            7'b0011111);
        chk("reset_data", {rdata, ram_dq_o}, 32'h0);
        chk("reset_addr", {14'b0, ram_addr}, 32'h0);

        // SRAM write, WAIT_CYCLES=1
        do_acc(0, 1, 16'h4000, 16'h1234);
        chk("wr_stall", n_stall, 3);
        chk("wr_we_low", n_we, 1);
        chk("wr_oe_cycles", n_oe, 2);
        chk("wr_dq", dq_seen, 16'h1234);
        chk("wr_addr", addr_seen, 18'h04000);
        chk("wr_done_strobes", {ram_we_n, ram_dq_oe, ram_en_n}, 3'b101);
        idle_bus();

        // SRAM read
        sram[16'h4000] = 16'hBEEF;
        do_acc(1, 0, 16'h4000, 16'h0000);
        chk("rd_stall", n_stall, 2);
        chk("rd_oe_low", n_rdoe, 1);
        chk("rd_we_low", n_we, 0);
        chk("rd_data", rd_val, 16'hBEEF);
        idle_bus();

        // Back-to-back: both controls high (write wins), then read back
        do_acc(1, 1, 16'h0010, 16'h5566);
        chk("b2b_wr_stall", n_stall, 3);
        chk("b2b_wr_we", n_we, 1);
        do_acc(1, 0, 16'h0010, 16'h0000);
        chk("b2b_rd_stall", n_stall, 2);
        chk("b2b_rd_we", n_we, 0);
        chk("b2b_rd_data", rd_val, 16'h5566);
        idle_bus();
        #1;
        chk("b2b_idle", {stall, ram_we_n, ram_oe_n}, 3'b011);

`ifdef MEM_RESP_UART_EN
        uart_tbre = 1; uart_tsre = 1; uart_data_ready = 0;
        repeat (3) @(negedge clk);
        do_acc(1, 0, 16'hBF01, 16'h0000);
        chk("stat_stall", n_stall, 1);
        chk("stat_tx", rd_val, 16'h0001);
        idle_bus();
        uart_data_ready = 1;
        repeat (3) @(negedge clk);
        do_acc(1, 0, 16'hBF01, 16'h0000);
        chk("stat_rxtx", rd_val, 16'h0003);
        idle_bus();

        do_acc(0, 1, 16'hBF00, 16'hAB41);
        chk("uwr_stall", n_stall, 3);
        chk("uwr_en", n_en, 0);
        chk("uwr_wrn", n_wrn, 1);
        chk("uwr_we", n_we, 0);
        chk("uwr_dq", dq_seen, 16'h0041);
        idle_bus();

        do_acc(1, 0, 16'hBF00, 16'h0000);
        chk("urd_stall", n_stall, 2);
        chk("urd_rdn", n_rdn, 1);
        chk("urd_data", rd_val, 16'h0077);
        idle_bus();
`else
        do_acc(0, 1, 16'hBF00, 16'hAB41);
        chk("bf00_wr_we", n_we, 1);
        chk("bf00_wr_wrn", n_wrn, 0);
        chk("bf00_wr_dq", dq_seen, 16'hAB41);
        idle_bus();
        sram[16'hBF01] = 16'h0F0F;
        do_acc(1, 0, 16'hBF01, 16'h0000);
        chk("bf01_rd_stall", n_stall, 2);
        chk("bf01_rd_rdn", n_rdn, 0);
        chk("bf01_rd_data", rd_val, 16'h0F0F);
        idle_bus();
`endif

        // WAIT_CYCLES=3 write latency, then reset in the middle of SRAM_WR
        begin
            int  s3 = 0;
            int  w3 = 0;
            bit  fin = 0;
            @(negedge clk);
            t3_wr = 1; t3_addr = 16'h0100; t3_wdata = 16'h7777;
            for (int i = 0; i < 20; i++) begin
                #1;
                if (!t3_stall) begin fin = 1; break; end
                s3++;
                if (!t3_we_n) w3++;
                @(negedge clk);
            end
            chk("w3_timeout", {31'b0, fin}, 32'd1);
            chk("w3_stall", s3, 5);
            chk("w3_we_low", w3, 3);
        end
        @(negedge clk);
        t3_wr = 0;
        @(negedge clk);
        t3_wr = 1; t3_addr = 16'h0200; t3_wdata = 16'h1111;
        @(negedge clk);
        #1;
        chk("rst3_pre_we", {31'b0, t3_we_n}, 32'd0);
        @(negedge clk);
        t3_rst = 1; t3_wr = 0;
        @(negedge clk);
        #1;
        chk("rst3_outs", {t3_stall, t3_dq_oe, t3_en_n, t3_oe_n, t3_we_n, t3_rdn, t3_wrn},
            7'b0011111);
        t3_rst = 0;
        @(negedge clk);
        #1;
        chk("rst3_idle", {t3_stall, t3_we_n, t3_dq_oe}, 3'b010);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_mem_access_responder

`default_nettype wire
